// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter that shares one FIFO write port between N_REQ requesters.
// Define FIFO_WR_ARB_PRIO0_EN to give requester 0 strict priority in every IDLE arbitration.
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic                       wfull,
    input  logic                       prog_full,
    output logic [N_REQ-1:0]           gnt,
    output logic                       wen,
    output logic [DATA_W-1:0]          wdata,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d, rr_ptr_q, rr_ptr_d, win;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, own_data;
    logic              ok, own_req, accept, found;

    always_comb begin
        ok       = !wfull && !prog_full;
        own_req  = 1'b0;
        own_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i)) begin
                own_req  = req[i];
                own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        accept = (state_q == BURST) && own_req && ok;
        gnt    = '0;
        for (int i = 0; i < N_REQ; i++) gnt[i] = accept && (owner_q == OW'(i));
        // Search starts just after the last burst owner and wraps around.
        win   = rr_ptr_q;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[OW'((int'(rr_ptr_q) + k) % N_REQ)]) begin
                win   = OW'((int'(rr_ptr_q) + k) % N_REQ);
                found = 1'b1;
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req[0]) win = '0;
`endif
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        wen_d      = accept;
        wdata_d    = accept ? own_data : wdata_q;
        if (state_q == IDLE) begin
            if (|req && ok) begin
                state_d    = BURST;
                owner_d    = win;
                beat_cnt_d = '0;
            end
        end else begin
            beat_cnt_d = accept ? beat_cnt_q + 1'b1 : beat_cnt_q;
            if (!own_req || (accept && beat_cnt_q == CW'(BURST_LEN - 1))) begin
                state_d = IDLE;
`ifdef FIFO_WR_ARB_PRIO0_EN
                rr_ptr_d = (owner_q != '0) ? owner_q : rr_ptr_q;
`else
                rr_ptr_d = owner_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= OW'(N_REQ - 1);
            wen_q      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
        end
    end

    assign wen   = wen_q;
    assign wdata = wdata_q;
    assign owner = owner_q;
    assign busy  = (state_q == BURST);
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed and randomized checks of fifo_wr_arb against a behavioural model.
// Honours FIFO_WR_ARB_PRIO0_EN in the expected owner sequences.
module tb_fifo_wr_arb;
    localparam int N = 4, DW = 4, BL = 4;

    logic            clk = 1'b0, rstn = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            wfull = 1'b0, prog_full = 1'b0;
    logic [N-1:0]    gnt;
    logic            wen, busy;
    logic [DW-1:0]   wdata;
    logic [1:0]      owner;

    fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .wfull(wfull),
        .prog_full(prog_full), .gnt(gnt), .wen(wen), .wdata(wdata), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit m_busy, m_wen, prev_busy;
    int m_owner, m_cnt, m_rr, wen_cnt;
    logic [DW-1:0] m_wdata;
    logic [N-1:0] acc = '0;
    int owners[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dat(int i);
        return req_data[i*DW +: DW];
    endfunction

    function automatic int pick();
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) if (req[(m_rr + k) % N]) return (m_rr + k) % N;
        return 0;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g = '0;
        if (m_busy && req[m_owner] && !wfull && !prog_full) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = N - 1; m_wen = 0; m_wdata = '0; prev_busy = 0;
    endtask

    task automatic model_update();
        bit ok, a;
        ok = !wfull && !prog_full;
        if (!m_busy) begin
            m_wen = 0;
            if (req != 0 && ok) begin
                m_busy = 1; m_owner = pick(); m_cnt = 0;
            end
        end else begin
            a = req[m_owner] && ok;
            m_wen = a;
            if (a) begin
                m_wdata = dat(m_owner);
                m_cnt++;
            end
            if (!req[m_owner] || m_cnt == BL) begin
                m_busy = 0;
`ifdef FIFO_WR_ARB_PRIO0_EN
                if (m_owner != 0) m_rr = m_owner;
`else
                m_rr = m_owner;
`endif
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(exp_gnt()));
        chk("wen", 32'(wen), 32'(m_wen));
        chk("wdata", 32'(wdata), 32'(m_wdata));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_busy));
        if (busy && !prev_busy) owners.push_back(int'(owner));
        prev_busy = busy;
        wen_cnt += int'(wen);
        acc = req & gnt;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic chk_owners(string tag, int e0, int e1, int e2, int e3, int e4, int n);
        int e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({tag, "_count"}, 32'(owners.size() >= n), 32'd1);
        for (int k = 0; k < n; k++) if (k < owners.size()) chk(tag, 32'(owners[k]), 32'(e[k]));
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        req = 4'b1111;
        req_data = 16'h8765;
        owners.delete();
        repeat (25) step();
`ifdef FIFO_WR_ARB_PRIO0_EN
        chk_owners("own_all", 0, 0, 0, 0, 0, 5);
`else
        chk_owners("own_all", 0, 1, 2, 3, 0, 5);
`endif
        req = 4'b1011;
        do_reset();
        owners.delete();
        repeat (25) step();
`ifdef FIFO_WR_ARB_PRIO0_EN
        chk_owners("own_1011", 0, 0, 0, 0, 0, 4);
`else
        chk_owners("own_1011", 0, 1, 3, 0, 0, 4);
`endif
        req = '0;
        repeat (2) step();
        req = 4'b0100;
        req_data[8 +: 4] = 4'hA;
        owners.delete();
        wen_cnt = 0;
        repeat (12) step();
        chk_owners("own_single", 2, 2, 0, 0, 0, 2);
        chk("wen_single", 32'(wen_cnt), 32'd8);
        req = '0;
        repeat (2) step();
        req = 4'b1000;
        wen_cnt = 0;
        repeat (3) step();
        prog_full = 1'b1;
        repeat (5) step();
        prog_full = 1'b0;
        repeat (3) step();
        chk("wen_stall", 32'(wen_cnt), 32'd4);
        req = '0;
        repeat (2) step();
        req = 4'b0011;
        owners.delete();
        wen_cnt = 0;
        repeat (2) step();
        req = 4'b0010;
        repeat (3) step();
        chk_owners("own_drop", 0, 1, 0, 0, 0, 2);
        chk("wen_drop", 32'(wen_cnt), 32'd1);
        req = '0;
        repeat (2) step();
        req = 4'b1111;
        repeat (4) step();
        rstn = 1'b0;
        #1;
        chk("mid_rst_wen", 32'(wen), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_wdata", 32'(wdata), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        owners.delete();
        repeat (3) step();
        chk_owners("own_after_rst", 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req[i]) req_data[i*DW +: DW] = DW'($urandom);
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            wfull = ($urandom_range(9) == 0);
            prog_full = ($urandom_range(9) == 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
